// File: rtl/bus_pkg.sv
// Shared bus definitions for the core datapath.
// Holds the default bus geometry and the index of every bus source in
// priority order (index 0 wins under fixed priority).
package bus_pkg;

    localparam int BUS_WIDTH = 16;
    localparam int N_BUS_SRC = 10;

    localparam int SRC_IM = 0;
    localparam int SRC_DR = 1;
    localparam int SRC_DM = 2;
    localparam int SRC_AC = 3;
    localparam int SRC_R  = 4;
    localparam int SRC_AR = 5;
    localparam int SRC_A  = 6;
    localparam int SRC_B  = 7;
    localparam int SRC_C  = 8;
    localparam int SRC_PC = 9;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner selection for the shared bus.
// Ports:
//   req        - per-source request vector
//   ptr        - index of the last granted source
//   rr_en      - 0: fixed priority from index 0, 1: round-robin after ptr
//   lock_valid - current grantee holds a lock; lock_idx wins unconditionally
//   lock_idx   - index of the current grantee
//   win_onehot - one-hot winner, all-zero when nothing requests
//   win_idx    - encoded winner index (meaningful only when any_req=1)
//   any_req    - at least one request is asserted
module rr_arbiter #(
    parameter  int N     = 10,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    input  logic             lock_valid,
    input  logic [IDX_W-1:0] lock_idx,
    output logic [N-1:0]     win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

    logic [IDX_W-1:0] start;
    logic [N-1:0]     rot_req;
    logic [IDX_W-1:0] ofs;
    logic [IDX_W:0]   sum;

    always_comb begin
        // Fixed priority is just a search that starts at index 0.
        start = '0;
        if (rr_en) begin
            start = (ptr == IDX_W'(N - 1)) ? '0 : ptr + IDX_W'(1);
        end

        // Rotating the doubled vector brings index 'start' to bit 0, so the
        // lowest set bit of the low half is the first requester in search order.
        rot_req = N'({req, req} >> start);

        ofs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) ofs = IDX_W'(i);
        end

        sum = {1'b0, ofs} + {1'b0, start};
        if (sum >= N_EXT) sum = sum - N_EXT;

        any_req = |req;
        win_idx = lock_valid ? lock_idx : sum[IDX_W-1:0];

        win_onehot = '0;
        if (any_req) win_onehot[win_idx] = 1'b1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Registered shared-bus multiplexer with fixed-priority / round-robin
// arbitration, grant locking and request-conflict statistics.
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   src_data     - packed source data, source i at [i*WIDTH +: WIDTH]
//   src_req      - per-source request
//   src_lock     - per-source lock request (only the grantee's bit matters)
//   rr_en        - 0: fixed priority, 1: round-robin
//   clr_stats    - synchronous clear of conflict_cnt
//   bus          - registered bus value, held while idle
//   bus_valid    - bus was loaded by a grant at the last edge
//   grant        - registered one-hot grant
//   conflict     - more than one request at the last edge
//   conflict_cnt - saturating count of conflict cycles
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int WIDTH = BUS_WIDTH,
    parameter  int N_SRC = N_BUS_SRC,
    parameter  int CNT_W = 8,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_req,
    input  logic [N_SRC-1:0]       src_lock,
    input  logic                   rr_en,
    input  logic                   clr_stats,
    output logic [WIDTH-1:0]       bus,
    output logic                   bus_valid,
    output logic [N_SRC-1:0]       grant,
    output logic                   conflict,
    output logic [CNT_W-1:0]       conflict_cnt
);

    logic [IDX_W-1:0] ptr;
    logic             lock_valid;
    logic [N_SRC-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic             multi_req;

    // ptr always follows the latest grant, so while grant is non-zero ptr is
    // the grantee's index and doubles as the lock index.
    assign lock_valid = |(grant & src_lock & src_req);

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_req = |(src_req & (src_req - N_SRC'(1)));

    rr_arbiter #(.N(N_SRC)) u_rr_arbiter (
        .req        (src_req),
        .ptr        (ptr),
        .rr_en      (rr_en),
        .lock_valid (lock_valid),
        .lock_idx   (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus          <= '0;
            bus_valid    <= 1'b0;
            grant        <= '0;
            ptr          <= IDX_W'(N_SRC - 1);
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (any_req) begin
                bus       <= src_data[win_idx*WIDTH +: WIDTH];
                grant     <= win_onehot;
                bus_valid <= 1'b1;
                ptr       <= win_idx;
            end else begin
                grant     <= '0;
                bus_valid <= 1'b0;
            end

            conflict <= multi_req;
            if (clr_stats) begin
                conflict_cnt <= '0;
            end else if (multi_req && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int W = 16;
    localparam int N = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N*W-1:0]   src_data = '0;
    logic [N-1:0]     src_req = '0;
    logic [N-1:0]     src_lock = '0;
    logic             rr_en = 1'b0;
    logic             clr_stats = 1'b0;

    logic [W-1:0]     bus, bus2;
    logic             bus_valid, bus_valid2;
    logic [N-1:0]     grant, grant2;
    logic             conflict, conflict2;
    logic [7:0]       conflict_cnt;
    logic [1:0]       conflict_cnt2;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(.WIDTH(W), .N_SRC(N), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_req(src_req),
        .src_lock(src_lock), .rr_en(rr_en), .clr_stats(clr_stats),
        .bus(bus), .bus_valid(bus_valid), .grant(grant),
        .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    bus_arbiter #(.WIDTH(W), .N_SRC(N), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_req(src_req),
        .src_lock(src_lock), .rr_en(rr_en), .clr_stats(clr_stats),
        .bus(bus2), .bus_valid(bus_valid2), .grant(grant2),
        .conflict(conflict2), .conflict_cnt(conflict_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: winner chosen by walking the rules directly.
    int       m_gidx;
    int       m_ptr;
    logic [W-1:0] m_bus;
    bit       m_conf;
    int       m_cnt8, m_cnt2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gidx = -1;
            m_ptr  = N - 1;
            m_bus  = '0;
            m_conf = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            int w;
            int n;
            w = -1;
            n = 0;
            for (int i = 0; i < N; i++) if (src_req[i]) n++;
            if (m_gidx >= 0 && src_lock[m_gidx] && src_req[m_gidx]) begin
                w = m_gidx;
            end else if (!rr_en) begin
                for (int i = 0; i < N; i++) if (w < 0 && src_req[i]) w = i;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (w < 0 && src_req[j]) w = j;
                end
            end
            m_conf = (n > 1);
            if (clr_stats) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (n > 1) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (w >= 0) begin
                m_bus  = src_data[w*W +: W];
                m_gidx = w;
                m_ptr  = w;
            end else begin
                m_gidx = -1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            logic [N-1:0] eg;
            eg = '0;
            if (m_gidx >= 0) eg[m_gidx] = 1'b1;
            chk("m_bus", 32'(bus), 32'(m_bus));
            chk("m_valid", 32'(bus_valid), 32'(m_gidx >= 0));
            chk("m_grant", 32'(grant), 32'(eg));
            chk("m_conflict", 32'(conflict), 32'(m_conf));
            chk("m_cnt8", 32'(conflict_cnt), 32'(m_cnt8));
            chk("m_cnt2", 32'(conflict_cnt2), 32'(m_cnt2));
            chk("m_grant2", 32'(grant2), 32'(eg));
        end
    end

    task automatic set_data(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    // Apply inputs (called at a negedge), then wait until the next negedge.
    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic rr, input logic clr);
        src_req   = req;
        src_lock  = lck;
        rr_en     = rr;
        clr_stats = clr;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] all_req;
        all_req = '1;

        repeat (2) @(negedge clk);
        chk("rst_bus", 32'(bus), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(bus_valid), 0);
        chk("rst_cnt", 32'(conflict_cnt), 0);
        rst_n = 1'b1;
        check_en = 1'b1;

        // Idle, single request from AC, then drop.
        cyc('0, '0, 1'b0, 1'b0);
        chk("idle_bus", 32'(bus), 0);
        chk("idle_grant", 32'(grant), 0);
        chk("idle_valid", 32'(bus_valid), 0);
        set_data(SRC_AC, 16'h1234);
        cyc(N'(1) << SRC_AC, '0, 1'b0, 1'b0);
        chk("ac_bus", 32'(bus), 32'h1234);
        chk("ac_grant", 32'(grant), 32'h008);
        chk("ac_valid", 32'(bus_valid), 1);
        set_data(SRC_AC, 16'hBEEF);
        cyc('0, '0, 1'b0, 1'b0);
        chk("hold_bus", 32'(bus), 32'h1234);
        chk("hold_valid", 32'(bus_valid), 0);

        // Fixed priority with every source requesting, then saturation and clear.
        for (int k = 0; k < 3; k++) begin
            cyc(all_req, '0, 1'b0, 1'b0);
            chk("fp_grant", 32'(grant), 32'h001);
            chk("fp_conflict", 32'(conflict), 1);
        end
        chk("fp_cnt8", 32'(conflict_cnt), 3);
        repeat (2) cyc(all_req, '0, 1'b0, 1'b0);
        chk("sat_cnt8", 32'(conflict_cnt), 5);
        chk("sat_cnt2", 32'(conflict_cnt2), 3);
        cyc(all_req, '0, 1'b0, 1'b1);
        chk("clr_cnt8", 32'(conflict_cnt), 0);
        chk("clr_cnt2", 32'(conflict_cnt2), 0);
        chk("clr_conflict", 32'(conflict), 1);

        // Fresh reset so round-robin starts searching at index 0.
        cyc('0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(all_req, '0, 1'b1, 1'b0);
            chk("rr_grant", 32'(grant), 32'(1) << (k % N));
        end

        // Lock: A and B requesting, A holds the bus while it keeps the lock.
        for (int i = 0; i < N; i++) set_data(i, 16'(16'hA000 + i));
        for (int k = 0; k < 4; k++) begin
            cyc((N'(1) << SRC_A) | (N'(1) << SRC_B), N'(1) << SRC_A, 1'b1, 1'b0);
            chk("lock_grant", 32'(grant), 32'h040);
        end
        cyc((N'(1) << SRC_A) | (N'(1) << SRC_B), '0, 1'b1, 1'b0);
        chk("unlock_grant", 32'(grant), 32'h080);
        chk("unlock_bus", 32'(bus), 32'hA007);

        // Reset in the middle of a locked transfer.
        cyc((N'(1) << SRC_A) | (N'(1) << SRC_B), N'(1) << SRC_A, 1'b1, 1'b0);
        chk("relock_grant", 32'(grant), 32'h040);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", 32'(bus), 0);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_valid", 32'(bus_valid), 0);
        chk("mid_rst_conflict", 32'(conflict), 0);
        chk("mid_rst_cnt", 32'(conflict_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(all_req, all_req, 1'b1, 1'b0);
        chk("post_rst_grant", 32'(grant), 32'h001);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) set_data(i, 16'($urandom));
            case ($urandom_range(0, 3))
                0: r = N'($urandom) & N'($urandom) & N'($urandom);
                1: r = N'(1) << $urandom_range(0, N - 1);
                2: r = '0;
                default: r = N'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(r, N'($urandom) | N'($urandom),
                ($urandom_range(0, 15) == 0) ? ~rr_en : rr_en,
                $urandom_range(0, 29) == 0);
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Registered, parametrised shared-bus multiplexer with arbitration for the core datapath. It replaces the combinational, latch-prone source select with a clocked arbiter. The arbiter selects one of N_SRC requesting register/memory sources in fixed-priority or round-robin mode and supports grant locking for multi-cycle transfers. Each cycle it drives the winner's data onto a registered bus with a one-hot grant and a valid flag, and it flags and counts request conflicts. It sits between all register/memory outputs and the shared bus consumers in each core.

## Interface
- WIDTH, 16, bus data width in bits
- N_SRC, 10, number of bus sources (≥2)
- CNT_W, 8, width of conflict counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- src_data  in  N_SRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH]
- src_req  in  N_SRC  per-source request (the former read enables)
- src_lock  in  N_SRC  per-source lock request; only the current grantee's bit is used
- rr_en  in  1  0 = fixed priority (index 0 highest), 1 = round-robin
- clr_stats  in  1  synchronous clear of conflict_cnt
- bus  out  WIDTH  registered bus value
- bus_valid  out  1  bus carries data granted this cycle
- grant  out  N_SRC  registered one-hot grant, all-zero when idle
- conflict  out  1  registered: more than one src_req was high in the previous cycle
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- Every cycle, compute winner w from src_req:
  - Lock: if grant[g]=1, src_lock[g]=1 and src_req[g]=1, then w=g regardless of other requests or mode.
  - Else, fixed priority (rr_en=0): lowest-index asserted request wins.
  - Else, round-robin (rr_en=1): first asserted request at index ptr+1, ptr+2, … wrapping modulo N_SRC.
- If w exists: bus←src_data[w], grant←onehot(w), bus_valid←1, ptr←w.
- If no request: bus holds its previous value (explicit register, no latch), grant←0, bus_valid←0, ptr unchanged.
- ptr updates on every grant in both modes, so toggling rr_en at run time is glitch-free and takes effect the same cycle.
- Lock release: the lock ends when the grantee deasserts either src_lock or src_req; the next arbitration is normal. A src_lock bit on a non-granted source is ignored.
- conflict←(popcount(src_req)>1). conflict_cnt increments when a conflict is detected, saturates at 2^CNT_W−1 and never wraps.
- clr_stats=1 zeroes conflict_cnt next cycle and takes priority over a simultaneous increment.

## Timing
- Latency 1 cycle: request/data sampled at edge k appear on bus/grant/bus_valid after edge k.
- Source data is sampled only at the grant edge. Later changes to src_data are not reflected until the source is granted again.
- Reset values (asynchronous, immediate on rst_n low): bus=0, bus_valid=0, grant=0, conflict=0, conflict_cnt=0, ptr=N_SRC−1 (so first round-robin search starts at index 0).
- Reset mid-lock drops the lock; the first post-reset arbitration is normal.
- With all N_SRC requesting continuously in round-robin mode, each source is granted exactly once every N_SRC cycles.

## Structure
- Shared package bus_pkg:
  - BUS_WIDTH=16, N_BUS_SRC=10.
  - Source index constants in priority order: SRC_IM=0, SRC_DR=1, SRC_DM=2, SRC_AC=3, SRC_R=4, SRC_AR=5, SRC_A=6, SRC_B=7, SRC_C=8, SRC_PC=9.
- One sub-module, rr_arbiter:
  - Purely combinational.
  - Inputs: req, ptr, rr_en, lock_valid, lock_idx.
  - Outputs: one-hot winner, encoded index, any-request.
  - Implemented with a double-width rotate/mask priority pick.
- bus_arbiter holds all registers: bus, grant, bus_valid, ptr, conflict, conflict_cnt.

## Test plan
- Reset, then src_req=0 → bus=0, grant=0, bus_valid=0. Then src_req=0b0000001000 (AC), src_data[AC]=16'h1234 → next cycle bus=16'h1234, grant=0x008, bus_valid=1. Drop req → bus stays 16'h1234, bus_valid=0.
- Fixed priority, src_req=0x3FF for 3 cycles → grant=0x001 each cycle, conflict=1, conflict_cnt=3.
- Round-robin, src_req=0x3FF for 12 cycles → grant sequence 0x001,0x002,…,0x200,0x001,0x002.
- Lock: round-robin with A and B requesting, A granted with src_lock[A]=1 for 4 cycles → grant stays A. Clear src_lock[A] → B granted the following cycle.
- Saturation/clear: CNT_W=2 with 5 conflict cycles → conflict_cnt=3. Assert clr_stats together with a conflict → conflict_cnt=0.
- Assert rst_n low mid-stream during a locked transfer → all outputs zero immediately. After release, round-robin with src_req=0x3FF grants index 0 first.
